// File: rtl/zle_xc_fsm_ctrl.sv
// rtl/zle_xc_fsm_ctrl.sv - control FSM for the ZLE encoder stream crossing
// Optional macro ZLE_XC_FSM_HALT_EN: after the EOS token the FSM parks in HALT until reset.
module zle_xc_fsm_ctrl (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_v,
    output logic       i_b_,
    output logic       o_v,
    input  logic       o_b,
    output logic [3:0] state,
    input  logic       f1,
    input  logic       f2,
    input  logic       f3
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_RUN   = 4'd1;
    localparam logic [3:0] S_LIT   = 4'd2;
    localparam logic [3:0] S_FLSAT = 4'd3;
    localparam logic [3:0] S_EOS   = 4'd4;
    localparam logic [3:0] S_FLEOS = 4'd5;
    localparam logic [3:0] S_FLLIT = 4'd6;
`ifdef ZLE_XC_FSM_HALT_EN
    localparam logic [3:0] S_HALT  = 4'd7;
`endif

    logic [3:0] next_state;
    logic       emit;

    assign emit = !o_b;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = S_IDLE;
        case (state)
            S_IDLE: begin
                if (!i_v)    next_state = S_IDLE;
                else if (f3) next_state = S_EOS;
                else if (f1) next_state = S_RUN;
                else         next_state = S_LIT;
            end
            S_RUN: begin
                // Saturation blocks input this cycle, so no token is consumed.
                if (f2)        next_state = S_FLSAT;
                else if (!i_v) next_state = S_RUN;
                else if (f3)   next_state = S_FLEOS;
                else if (f1)   next_state = S_RUN;
                else           next_state = S_FLLIT;
            end
            S_LIT:   next_state = emit ? S_IDLE : S_LIT;
            S_FLSAT: next_state = emit ? S_IDLE : S_FLSAT;
`ifdef ZLE_XC_FSM_HALT_EN
            S_EOS:   next_state = emit ? S_HALT : S_EOS;
            S_HALT:  next_state = S_HALT;
`else
            S_EOS:   next_state = emit ? S_IDLE : S_EOS;
`endif
            S_FLEOS: next_state = emit ? S_EOS : S_FLEOS;
            S_FLLIT: next_state = emit ? S_LIT : S_FLLIT;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        i_b_ = 1'b0;
        o_v  = 1'b0;
        if (!reset) begin
            case (state)
                S_IDLE:  i_b_ = 1'b1;
                S_RUN:   i_b_ = !f2;
                S_LIT, S_FLSAT, S_EOS, S_FLEOS, S_FLLIT: o_v = 1'b1;
                default: begin
                    i_b_ = 1'b0;
                    o_v  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zle_xc_fsm_ctrl.sv
// tb/tb_zle_xc_fsm_ctrl.sv - bench for zle_xc_fsm_ctrl: vector table plus token-queue reference model
module tb_zle_xc_fsm_ctrl;

`ifdef ZLE_XC_FSM_HALT_EN
    localparam bit HALT = 1'b1;
`else
    localparam bit HALT = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       i_v = 1'b0;
    logic       i_b_;
    logic       o_v;
    logic       o_b = 1'b0;
    logic [3:0] state;
    logic       f1 = 1'b0;
    logic       f2 = 1'b0;
    logic       f3 = 1'b0;

    zle_xc_fsm_ctrl dut (
        .clock(clock),
        .reset(reset),
        .i_v  (i_v),
        .i_b_ (i_b_),
        .o_v  (o_v),
        .o_b  (o_b),
        .state(state),
        .f1   (f1),
        .f2   (f2),
        .f3   (f3)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit       rst;
        bit       iv;
        bit       ob;
        bit       a1;
        bit       a2;
        bit       a3;
        int       st;
        bit       ib;
        bit       ov;
    } vec_t;

    vec_t vecs[$];
    int   n_pass = 0;
    int   n_total = 0;

    // Reference model: pending output tokens in order, plus run/halt flags.
    localparam int K_LIT = 0, K_SAT = 1, K_EOS = 2, K_CNT = 3;
    int pend[$];
    bit in_run = 1'b0;
    bit halted = 1'b0;

    task automatic add(input bit rst, input bit iv, input bit ob, input bit a1, input bit a2,
                       input bit a3, input int st, input bit ib, input bit ov);
        vec_t v;
        v.rst = rst; v.iv = iv; v.ob = ob; v.a1 = a1; v.a2 = a2; v.a3 = a3;
        v.st = st; v.ib = ib; v.ov = ov;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input bit rst, input bit iv, input bit ob, input bit a1, input bit a2, input bit a3);
        reset = rst; i_v = iv; o_b = ob; f1 = a1; f2 = a2; f3 = a3;
    endtask

    function automatic int model_state();
        if (halted) return 7;
        if (pend.size() != 0) begin
            case (pend[0])
                K_LIT: return 2;
                K_SAT: return 3;
                K_EOS: return 4;
                default: return (pend[1] == K_EOS) ? 5 : 6;
            endcase
        end
        return in_run ? 1 : 0;
    endfunction

    function automatic bit model_ib(input bit rst, input bit a2);
        return !rst && !halted && pend.size() == 0 && (!in_run || !a2);
    endfunction

    function automatic bit model_ov(input bit rst);
        return !rst && pend.size() != 0;
    endfunction

    task automatic model_step(input bit rst, input bit iv, input bit ob, input bit a1, input bit a2, input bit a3);
        int k;
        if (rst) begin
            pend.delete();
            in_run = 1'b0;
            halted = 1'b0;
        end else if (pend.size() != 0) begin
            if (!ob) begin
                k = pend.pop_front();
                if (k == K_EOS && HALT) halted = 1'b1;
            end
        end else if (halted) begin
        end else if (in_run && a2) begin
            pend.push_back(K_SAT);
            in_run = 1'b0;
        end else if (iv) begin
            if (a3) begin
                if (in_run) pend.push_back(K_CNT);
                pend.push_back(K_EOS);
                in_run = 1'b0;
            end else if (a1) begin
                in_run = 1'b1;
            end else begin
                if (in_run) pend.push_back(K_CNT);
                pend.push_back(K_LIT);
                in_run = 1'b0;
            end
        end
    endtask

    initial begin
        // reset hold with traffic offered
        add(1,1,0,0,0,0, 0,0,0);
        add(1,1,0,0,0,0, 0,0,0);
        add(0,0,0,0,0,0, 0,1,0);
        // literal path
        add(0,1,0,0,0,0, 0,1,0);
        add(0,0,0,0,0,0, 2,0,1);
        add(0,0,0,0,0,0, 0,1,0);
        // back-pressure in LIT for 5 cycles
        add(0,1,0,0,0,0, 0,1,0);
        for (int i = 0; i < 5; i++) add(0,0,1,0,0,0, 2,0,1);
        add(0,0,0,0,0,0, 2,0,1);
        add(0,0,0,0,0,0, 0,1,0);
        // zero, zero, literal
        add(0,1,0,1,0,0, 0,1,0);
        add(0,1,0,1,0,0, 1,1,0);
        add(0,1,0,0,0,0, 1,1,0);
        add(0,0,0,0,0,0, 6,0,1);
        add(0,0,0,0,0,0, 2,0,1);
        add(0,0,0,0,0,0, 0,1,0);
        // saturation: i_b_ drops in the same cycle as f2
        add(0,1,0,1,0,0, 0,1,0);
        add(0,0,0,0,0,0, 1,1,0);
        add(0,1,0,1,1,0, 1,0,0);
        add(0,0,0,0,0,0, 3,0,1);
        add(0,0,0,0,0,0, 0,1,0);
        // zero then EOS (f3 wins over f1)
        add(0,1,0,1,0,0, 0,1,0);
        add(0,1,0,1,0,1, 1,1,0);
        add(0,0,0,0,0,0, 5,0,1);
        add(0,0,0,0,0,0, 4,0,1);
        add(0,1,0,0,0,0, HALT ? 7 : 0, !HALT, 0);
        add(0,0,0,0,0,0, HALT ? 7 : 2, 0, !HALT);
        add(1,0,0,0,0,0, HALT ? 7 : 0, 0, 0);
        add(0,0,0,0,0,0, 0,1,0);
        // EOS straight from IDLE, abandoned by reset while stalled
        add(0,1,0,1,0,1, 0,1,0);
        add(0,0,1,0,0,0, 4,0,1);
        add(1,0,1,0,0,0, 4,0,0);
        add(0,0,0,0,0,0, 0,1,0);

        drive(1,0,0,0,0,0);
        @(posedge clock);
        foreach (vecs[i]) begin
            @(negedge clock);
            drive(vecs[i].rst, vecs[i].iv, vecs[i].ob, vecs[i].a1, vecs[i].a2, vecs[i].a3);
            #1;
            check($sformatf("vec%0d state", i), state, vecs[i].st);
            check($sformatf("vec%0d i_b_", i), i_b_, vecs[i].ib);
            check($sformatf("vec%0d o_v", i), o_v, vecs[i].ov);
        end
        @(posedge clock);

        // randomized run against the token-queue model
        pend.delete();
        in_run = 1'b0;
        halted = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            bit rst, iv, ob, a1, a2, a3;
            rst = (n == 0) || ($urandom_range(0, 99) < 2);
            iv  = $urandom_range(0, 99) < 75;
            ob  = $urandom_range(0, 99) < 30;
            a1  = $urandom_range(0, 99) < 40;
            a2  = $urandom_range(0, 99) < 15;
            a3  = $urandom_range(0, 99) < 10;
            @(negedge clock);
            drive(rst, iv, ob, a1, a2, a3);
            #1;
            check("rand state", state, model_state());
            check("rand i_b_", i_b_, model_ib(rst, a2));
            check("rand o_v", o_v, model_ov(rst));
            check("rand exclusive", i_b_ & o_v, 0);
            @(posedge clock);
            model_step(rst, iv, ob, a1, a2, a3);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
